register_file: RTL and testbench

- LEGv8 register file: 32 x 64-bit, two combinational read ports, one synchronous write port.
- Read port 2 address comes from the Reg2Loc operand-select mux (Rm or Rt). Read port 1 takes Rn directly. The write port is driven by the write-back stage (Rd).
- X31 (XZR) always reads zero and ignores writes.
- Optional same-cycle write-to-read bypass, plus a debug read port for bench and inspection.

---
 rtl/legv8_pkg.sv | 9 +
 rtl/regfile_read_port.sv | 30 +++
 rtl/register_file.sv | 93 +++++++++
 tb/tb_register_file.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 architectural constants for the register file slice.
package legv8_pkg;

    localparam int DATA_WIDTH     = 64;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int XZR_INDEX      = 31;
    localparam int NUM_REGS       = 32;

endpackage

// File: rtl/regfile_read_port.sv
// One register-file read port: XZR forcing, optional write bypass, array select.
module regfile_read_port
    import legv8_pkg::*;
#(
    parameter int DATA_WIDTH = legv8_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int ZERO_REG   = XZR_INDEX,
    parameter bit BYPASS     = 1'b1
) (
    input  logic [(1 << ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
    input  logic [ADDR_WIDTH-1:0]                        read_addr,
    input  logic                                         wr_en,
    input  logic [ADDR_WIDTH-1:0]                        wr_addr,
    input  logic [DATA_WIDTH-1:0]                        wr_data,
    output logic [DATA_WIDTH-1:0]                        read_data
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    // wr_en already excludes reset and XZR writes, so only the index compare is needed here.
    always_comb begin
        read_data = regs[read_addr];
        if (read_addr == ZERO_IDX) begin
            read_data = '0;
        end else if (BYPASS && wr_en && (read_addr == wr_addr)) begin
            read_data = wr_data;
        end
    end

endmodule

// File: rtl/register_file.sv
// LEGv8 register file: 32 x 64-bit, two combinational read ports, one
// synchronous write port, XZR hardwired to zero, plus an unbypassed debug port.
module register_file
    import legv8_pkg::*;
#(
    parameter int DATA_WIDTH = legv8_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int ZERO_REG   = XZR_INDEX,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] Read_register1,
    input  logic [ADDR_WIDTH-1:0] Read_register2,
    input  logic [ADDR_WIDTH-1:0] Write_register,
    input  logic [DATA_WIDTH-1:0] Write_data,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] Debug_register,
    output logic [DATA_WIDTH-1:0] Read_data1,
    output logic [DATA_WIDTH-1:0] Read_data2,
    output logic [DATA_WIDTH-1:0] Debug_data,
    output logic [15:0]           Write_count
);

    localparam int                    ENTRIES  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [ENTRIES-1:0][DATA_WIDTH-1:0] mem;
    logic [15:0]                        write_count;
    logic                               commit;
    logic                               bypass_en;

    // An unknown RegWrite or index makes this compare non-true, so no write occurs.
    assign commit    = RegWrite && (Write_register != ZERO_IDX);
    assign bypass_en = commit && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem         <= '0;
            write_count <= '0;
        end else if (commit) begin
            mem[Write_register] <= Write_data;
            if (write_count != '1) begin
                write_count <= write_count + 16'd1;
            end
        end
    end

    assign Write_count = write_count;

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_read_port1 (
        .regs      (mem),
        .read_addr (Read_register1),
        .wr_en     (bypass_en),
        .wr_addr   (Write_register),
        .wr_data   (Write_data),
        .read_data (Read_data1)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_read_port2 (
        .regs      (mem),
        .read_addr (Read_register2),
        .wr_en     (bypass_en),
        .wr_addr   (Write_register),
        .wr_data   (Write_data),
        .read_data (Read_data2)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (1'b0)
    ) u_debug_port (
        .regs      (mem),
        .read_addr (Debug_register),
        .wr_en     (bypass_en),
        .wr_addr   (Write_register),
        .wr_data   (Write_data),
        .read_data (Debug_data)
    );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a bypassing and a non-bypassing instance share stimulus,
// checked every cycle against an array model plus directed literal expectations.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rr1, rr2, wr, dbg;
    logic [63:0] wdata;
    logic        we;

    logic [63:0] b_rd1, b_rd2, b_dbg;
    logic [15:0] b_cnt;
    logic [63:0] n_rd1, n_rd2, n_dbg;
    logic [15:0] n_cnt;

    int checks = 0;
    int errors = 0;

    logic [63:0] model_mem [32];
    int          model_cnt;
    bit          model_valid = 1'b0;

    always #5 clk = ~clk;

    register_file #(.BYPASS(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .Read_register1(rr1), .Read_register2(rr2),
        .Write_register(wr), .Write_data(wdata), .RegWrite(we),
        .Debug_register(dbg),
        .Read_data1(b_rd1), .Read_data2(b_rd2), .Debug_data(b_dbg),
        .Write_count(b_cnt)
    );

    register_file #(.BYPASS(1'b0)) u_nbp (
        .clk(clk), .reset(reset),
        .Read_register1(rr1), .Read_register2(rr2),
        .Write_register(wr), .Write_data(wdata), .RegWrite(we),
        .Debug_register(dbg),
        .Read_data1(n_rd1), .Read_data2(n_rd2), .Debug_data(n_dbg),
        .Write_count(n_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural view of a read, straight from the register-file rules.
    function automatic logic [63:0] exp_read(input logic [4:0] idx, input bit bypass);
        if (idx == 5'd31) return 64'd0;
        if (bypass && we && !reset && idx == wr) return wdata;
        return model_mem[idx];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            foreach (model_mem[i]) model_mem[i] = 64'd0;
            model_cnt   = 0;
            model_valid = 1'b1;
        end else if (we === 1'b1 && wr != 5'd31) begin
            model_mem[wr] = wdata;
            if (model_cnt < 65535) model_cnt = model_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_b_rd1", b_rd1, exp_read(rr1, 1'b1));
            chk("model_b_rd2", b_rd2, exp_read(rr2, 1'b1));
            chk("model_b_dbg", b_dbg, exp_read(dbg, 1'b0));
            chk("model_b_cnt", {48'd0, b_cnt}, 64'(model_cnt));
            chk("model_n_rd1", n_rd1, exp_read(rr1, 1'b0));
            chk("model_n_rd2", n_rd2, exp_read(rr2, 1'b0));
            chk("model_n_dbg", n_dbg, exp_read(dbg, 1'b0));
            chk("model_n_cnt", {48'd0, n_cnt}, 64'(model_cnt));
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; we = 1'b0; wr = '0; wdata = '0;
        rr1 = '0; rr2 = '0; dbg = '0;
        adv();
        reset = 1'b0;

        // Reset state on every index
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i); rr2 = 5'(31 - i); dbg = 5'(i);
            @(negedge clk);
            chk("reset_rd1", b_rd1, 64'd0);
            chk("reset_rd2", b_rd2, 64'd0);
            chk("reset_dbg", b_dbg, 64'd0);
            adv();
        end
        chk("reset_cnt", {48'd0, b_cnt}, 64'd0);

        // Write X5
        we = 1'b1; wr = 5'd5; wdata = 64'h0123_4567_89AB_CDEF; rr1 = 5'd5; rr2 = 5'd5;
        adv();
        we = 1'b0;
        @(negedge clk);
        chk("x5_rd1", b_rd1, 64'h0123_4567_89AB_CDEF);
        chk("x5_rd2", b_rd2, 64'h0123_4567_89AB_CDEF);
        chk("x5_nbp_rd1", n_rd1, 64'h0123_4567_89AB_CDEF);
        chk("x5_cnt", {48'd0, b_cnt}, 64'd1);
        adv();

        // Write to XZR is ignored
        we = 1'b1; wr = 5'd31; wdata = '1; rr1 = 5'd31;
        @(negedge clk);
        chk("xzr_same_cycle", b_rd1, 64'd0);
        adv();
        we = 1'b0;
        @(negedge clk);
        chk("xzr_next_cycle", b_rd1, 64'd0);
        chk("xzr_cnt", {48'd0, b_cnt}, 64'd1);
        adv();

        // Same-cycle bypass vs stored value
        we = 1'b1; wr = 5'd9; wdata = 64'hDEAD_BEEF; rr2 = 5'd9; dbg = 5'd9;
        @(negedge clk);
        chk("byp_rd2", b_rd2, 64'hDEAD_BEEF);
        chk("byp_dbg", b_dbg, 64'd0);
        chk("nbp_rd2_pre", n_rd2, 64'd0);
        adv();
        we = 1'b0;
        @(negedge clk);
        chk("nbp_rd2_post", n_rd2, 64'hDEAD_BEEF);
        chk("byp_dbg_post", b_dbg, 64'hDEAD_BEEF);
        chk("byp_cnt", {48'd0, b_cnt}, 64'd2);
        adv();

        // Reset wins over a simultaneous write
        we = 1'b1; wr = 5'd3; wdata = 64'd7; adv();
        wr = 5'd4; wdata = 64'd9; adv();
        reset = 1'b1; wr = 5'd3; wdata = 64'd1; rr1 = 5'd3; rr2 = 5'd4;
        @(negedge clk);
        chk("rst_no_bypass", b_rd1, 64'd7);
        chk("rst_cnt_pre", {48'd0, b_cnt}, 64'd4);
        adv();
        reset = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("rst_x3", b_rd1, 64'd0);
        chk("rst_x4", b_rd2, 64'd0);
        chk("rst_cnt", {48'd0, b_cnt}, 64'd0);
        adv();

        // Sweep X0..X30 then read back pairwise
        we = 1'b1;
        for (int i = 0; i < 31; i++) begin
            wr = 5'(i); wdata = 64'(i + 1);
            adv();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i += 2) begin
            rr1 = 5'(i); rr2 = 5'(i + 1); dbg = 5'(i);
            @(negedge clk);
            chk("sweep_rd1", b_rd1, (i == 31) ? 64'd0 : 64'(i + 1));
            chk("sweep_rd2", b_rd2, (i + 1 == 31) ? 64'd0 : 64'(i + 2));
            adv();
            rr2 = 5'(i);
            @(negedge clk);
            chk("sweep_same_rd2", b_rd2, 64'(i + 1));
            adv();
        end
        chk("sweep_cnt", {48'd0, b_cnt}, 64'd31);
        chk("sweep_nbp_cnt", {48'd0, n_cnt}, 64'd31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
